// File: rtl/parking_lot_counter.sv
// Gate occupancy tracker: synchronises two beam sensors, decodes enter/exit sequences, saturating 0..CAPACITY count.
// Latency 2 cycles from input capture to cnt/pulse; no backpressure (free-running sensor inputs).
module parking_lot_counter #(
   parameter int unsigned CAPACITY = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic [4:0] cnt,
   output logic       enter_p,
   output logic       exit_p,
   output logic       full,
   output logic       empty
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EN1  = 3'd1,
      EN2  = 3'd2,
      EN3  = 3'd3,
      EX1  = 3'd4,
      EX2  = 3'd5,
      EX3  = 3'd6
   } state_t;

   localparam logic [4:0] CAP = 5'(CAPACITY);

   logic       a_meta_q, a_s_q, b_meta_q, b_s_q;
   logic [1:0] s;
   state_t     state_q, state_d;
   logic       entry_evt, exit_evt;
   logic [4:0] cnt_q, cnt_d;
   logic       enter_q, enter_d, exit_q, exit_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_meta_q <= 1'b0;
         a_s_q    <= 1'b0;
         b_meta_q <= 1'b0;
         b_s_q    <= 1'b0;
      end else begin
         a_meta_q <= a;
         a_s_q    <= a_meta_q;
         b_meta_q <= b;
         b_s_q    <= b_meta_q;
      end
   end

   assign s = {a_s_q, b_s_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Exit states mirror the entry states with the beams swapped (10 <-> 01).
   always_comb begin
      state_d   = state_q;
      entry_evt = 1'b0;
      exit_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (s == 2'b10)      state_d = EN1;
            else if (s == 2'b01) state_d = EX1;
         end
         EN1: begin
            if (s == 2'b11)      state_d = EN2;
            else if (s != 2'b10) state_d = IDLE;
         end
         EN2: begin
            case (s)
               2'b01:   state_d = EN3;
               2'b10:   state_d = EN1;
               2'b00:   state_d = IDLE;
               default: state_d = EN2;
            endcase
         end
         EN3: begin
            case (s)
               2'b11:   state_d = EN2;
               2'b10:   state_d = IDLE;
               2'b00: begin
                  state_d   = IDLE;
                  entry_evt = 1'b1;
               end
               default: state_d = EN3;
            endcase
         end
         EX1: begin
            if (s == 2'b11)      state_d = EX2;
            else if (s != 2'b01) state_d = IDLE;
         end
         EX2: begin
            case (s)
               2'b10:   state_d = EX3;
               2'b01:   state_d = EX1;
               2'b00:   state_d = IDLE;
               default: state_d = EX2;
            endcase
         end
         EX3: begin
            case (s)
               2'b11:   state_d = EX2;
               2'b01:   state_d = IDLE;
               2'b00: begin
                  state_d  = IDLE;
                  exit_evt = 1'b1;
               end
               default: state_d = EX3;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses fire even when saturated: the car really moved, only the count holds.
   always_comb begin
      cnt_d   = cnt_q;
      enter_d = 1'b0;
      exit_d  = 1'b0;
      if (entry_evt) begin
         enter_d = 1'b1;
         if (cnt_q < CAP) cnt_d = cnt_q + 5'd1;
      end else if (exit_evt) begin
         exit_d = 1'b1;
         if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= 5'd0;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         enter_q <= enter_d;
         exit_q  <= exit_d;
      end
   end

   assign cnt     = cnt_q;
   assign enter_p = enter_q;
   assign exit_p  = exit_q;
   assign full    = (cnt_q == CAP);
   assign empty   = (cnt_q == 5'd0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Directed bench for parking_lot_counter: per-cycle vector table plus hand sequences for reset, saturation and underflow.
module tb_parking_lot_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic [4:0] cnt;
   logic       enter_p, exit_p, full, empty;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0] ab;
      int         reps;
      int         cnt;
      logic       en;
      logic       ex;
   } vec_t;

   vec_t tbl[$];

   parking_lot_counter #(.CAPACITY(25)) dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .cnt     (cnt),
      .enter_p (enter_p),
      .exit_p  (exit_p),
      .full    (full),
      .empty   (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int ecnt, input logic een, input logic eex);
      chk({tag, " cnt"}, int'(cnt), ecnt);
      chk({tag, " enter_p"}, int'(enter_p), int'(een));
      chk({tag, " exit_p"}, int'(exit_p), int'(eex));
      chk({tag, " full"}, int'(full), (ecnt == 25) ? 1 : 0);
      chk({tag, " empty"}, int'(empty), (ecnt == 0) ? 1 : 0);
   endtask

   task automatic add(input logic [1:0] ab, input int reps, input int c, input logic en, input logic ex);
      vec_t v;
      v.ab = ab; v.reps = reps; v.cnt = c; v.en = en; v.ex = ex;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Fast (1-cycle dwell) complete sequence; pulse expected exactly 2 cycles after 00 is captured.
   task automatic run_seq(input bit is_entry, input int exp_cnt);
      logic [1:0] p [4];
      if (is_entry) begin
         p[0] = 2'b10; p[1] = 2'b11; p[2] = 2'b01; p[3] = 2'b00;
      end else begin
         p[0] = 2'b01; p[1] = 2'b11; p[2] = 2'b10; p[3] = 2'b00;
      end
      for (int i = 0; i < 4; i++) begin
         {a, b} = p[i];
         tick();
      end
      tick();
      chk("seq quiet before", int'({enter_p, exit_p}), 0);
      tick();
      chk_all(is_entry ? "seq entry" : "seq exit", exp_cnt, is_entry, !is_entry);
      tick();
      chk("seq quiet after", int'({enter_p, exit_p}), 0);
   endtask

   initial begin
      // single entry, 3 cycles per pattern
      add(2'b00, 3, 0, 0, 0);
      add(2'b10, 3, 0, 0, 0); add(2'b11, 3, 0, 0, 0); add(2'b01, 3, 0, 0, 0);
      add(2'b00, 2, 0, 0, 0); add(2'b00, 1, 1, 1, 0); add(2'b00, 2, 1, 0, 0);
      // aborts
      add(2'b10, 3, 1, 0, 0); add(2'b00, 3, 1, 0, 0);
      add(2'b10, 3, 1, 0, 0); add(2'b11, 3, 1, 0, 0); add(2'b10, 3, 1, 0, 0); add(2'b00, 3, 1, 0, 0);
      // EN3 -> EN2 -> EN3 wobble still counts once
      add(2'b10, 3, 1, 0, 0); add(2'b11, 3, 1, 0, 0); add(2'b01, 3, 1, 0, 0);
      add(2'b11, 3, 1, 0, 0); add(2'b01, 3, 1, 0, 0);
      add(2'b00, 2, 1, 0, 0); add(2'b00, 1, 2, 1, 0); add(2'b00, 2, 2, 0, 0);
      // ambiguous 11 from IDLE, and 1-cycle 10 glitches
      add(2'b11, 3, 2, 0, 0); add(2'b00, 3, 2, 0, 0);
      add(2'b10, 1, 2, 0, 0); add(2'b00, 3, 2, 0, 0);
      add(2'b10, 1, 2, 0, 0); add(2'b00, 3, 2, 0, 0);
      // minimum dwell: each pattern for one cycle
      add(2'b10, 1, 2, 0, 0); add(2'b11, 1, 2, 0, 0); add(2'b01, 1, 2, 0, 0);
      add(2'b00, 2, 2, 0, 0); add(2'b00, 1, 3, 1, 0); add(2'b00, 2, 3, 0, 0);
      // one exit
      add(2'b01, 3, 3, 0, 0); add(2'b11, 3, 3, 0, 0); add(2'b10, 3, 3, 0, 0);
      add(2'b00, 2, 3, 0, 0); add(2'b00, 1, 2, 0, 1); add(2'b00, 2, 2, 0, 0);

      // reset values while held
      #12;
      chk_all("reset hold", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            {a, b} = tbl[i].ab;
            tick();
            chk_all($sformatf("vec%0d.%0d", i, r), tbl[i].cnt, tbl[i].en, tbl[i].ex);
         end
      end

      // bring count to 7, then reset in the middle of an entry
      for (int i = 0; i < 5; i++) run_seq(1'b1, 3 + i);
      chk("cnt before reset", int'(cnt), 7);
      {a, b} = 2'b10; tick();
      {a, b} = 2'b11; tick();
      #2 reset = 1'b0;
      #1;
      chk_all("async reset", 0, 0, 0);
      {a, b} = 2'b01;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("post-reset 01 c%0d", i), 0, 0, 0);
      end
      {a, b} = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all($sformatf("post-reset 00 c%0d", i), 0, 0, 0);
      end

      // fill to capacity; 26th entry pulses with count held
      for (int i = 0; i < 26; i++) run_seq(1'b1, (i < 25) ? i + 1 : 25);
      chk("full flag", int'(full), 1);

      // drain to 1, then two exits: last one underflows-held
      for (int i = 0; i < 24; i++) run_seq(1'b0, 24 - i);
      chk("cnt at 1", int'(cnt), 1);
      run_seq(1'b0, 0);
      run_seq(1'b0, 0);
      chk("empty flag", int'(empty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/parking_lot_counter.md
# parking_lot_counter

Occupancy tracker for the single-lane parking lot. Watches two photo-sensor beams at the gate, recognises complete car-enter and car-exit sequences, and keeps a saturating 0..CAPACITY car count. Its `cnt` output drives the 5-bit count input of the downstream hex display stage, which renders CLEAR0 at 0, digits at 1..24 and FULL25 at 25. It also produces event pulses and full/empty flags for LEDs.

## Interface
- `CAPACITY`, 25: maximum occupancy. Must be ≤ 31.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  1  outer beam, raw and asynchronous; 1 = blocked.
- `b`  in  1  inner beam, raw and asynchronous; 1 = blocked.
- `cnt`  out  5  current occupancy, 0..CAPACITY; feeds the display stage.
- `enter_p`  out  1  one-cycle pulse when an entry is counted.
- `exit_p`  out  1  one-cycle pulse when an exit is counted.
- `full`  out  1  high when `cnt == CAPACITY`.
- `empty`  out  1  high when `cnt == 0`.

## Operation
- **Input synchronisation**
  - `a` and `b` each pass through a 2-flop synchroniser.
  - The FSM only ever sees the synchronised pair `s = {a_s, b_s}`.
- **FSM states:** IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
- **IDLE**
  - s = 10 → EN1.
  - s = 01 → EX1.
  - s = 00 or 11 → stay (11 from IDLE is ambiguous and is ignored).
- **EN1**
  - s = 10 → stay.
  - s = 11 → EN2.
  - s = 00 or 01 → IDLE (abort).
- **EN2**
  - s = 11 → stay.
  - s = 01 → EN3.
  - s = 10 → EN1 (car backing out).
  - s = 00 → IDLE (abort).
- **EN3**
  - s = 01 → stay.
  - s = 11 → EN2.
  - s = 10 → IDLE (abort).
  - s = 00 → IDLE and an entry event.
- **Exit path:** EX1/EX2/EX3 mirror EN1/EN2/EN3 with `a` and `b` swapped (sequence 01, 11, 10, 00 produces an exit event).
- **Entry event**
  - If `cnt < CAPACITY`: `cnt` increments and `enter_p` asserts.
  - If `cnt == CAPACITY`: `cnt` holds and `enter_p` still asserts (the car physically entered; the display already shows FULL).
- **Exit event**
  - If `cnt > 0`: `cnt` decrements and `exit_p` asserts.
  - If `cnt == 0`: `cnt` holds and `exit_p` still asserts.
- **Arithmetic:** `cnt` is 5-bit unsigned and never wraps. Saturation is checked before the add/subtract.
- **Flags:** `full` and `empty` are decoded combinationally from the registered `cnt`.
- **Pulse exclusivity:** the FSM is in exactly one path, so `enter_p` and `exit_p` are never high in the same cycle.

## Timing
- **Reset values** (async, while `reset` = 0):
  - state = IDLE, both synchroniser stages = 0, `cnt` = 0.
  - `enter_p` = 0, `exit_p` = 0, `full` = 0, `empty` = 1.
- **Latency**
  - A raw input change first captured at edge k reaches the FSM at edge k+1.
  - The FSM registers its resulting state at edge k+2.
  - On a completing transition, `cnt` and the pulse update at edge k+2, i.e. 2 cycles after capture.
- **Pulse width:** `enter_p`/`exit_p` are registered and high for exactly one cycle, in the same cycle `cnt` shows its new value.
- **Hold/dwell:** each sensor pattern may persist for any number of cycles, including exactly 1 cycle after synchronisation; no minimum dwell is required.
- **Reset mid-sequence:** a partial sequence is discarded. After release, a car still in the beams must produce a fresh 10 → 11 → 01 → 00 (or mirror) from IDLE to be counted.
- **Reset deassertion:** asynchronous assertion; deassertion is expected synchronous to `clk` at board level. The first FSM decision uses post-reset synchroniser contents (00).

## Test plan
- **Reset:** assert `reset` = 0 mid-run with `cnt` = 7 → `cnt` = 0, `empty` = 1, `full` = 0 immediately; no pulse after release.
- **Single entry:** ab = 00, 10, 11, 01, 00 (3 cycles each) → `cnt` 0→1 and a single 1-cycle `enter_p`, exactly 2 cycles after 00 is captured.
- **Fill and saturate:** 26 entry sequences → `cnt` reaches 25 and `full` = 1; the 26th still pulses `enter_p` with `cnt` held at 25.
- **Exit and underflow:** from `cnt` = 1, two exit sequences (01, 11, 10, 00) → `cnt` = 0, `empty` = 1; the second gives `exit_p` with `cnt` held at 0.
- **Aborts and back-out:** 10, 00 → no event. 10, 11, 10, 00 → no event. 10, 11, 01, 11, 01, 00 → exactly one entry.
- **Glitch/ambiguous:** from IDLE apply 11 then 00, and 1-cycle 10 pulses → no count change, no pulses.
